// File: rtl/mem_request_master.sv
// Load/store initiator for the memory controller's enable/op_r handshake.
// Optional build macro MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_request_master #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_op_r,
  output logic              mem_enable,
  output logic [1:0]        mem_mode
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic req_bad;
  logic req_illegal;
  logic req_misalign;
  logic [1:0] req_mode;
  logic unused_addr_hi;

  assign unused_addr_hi = ^req_addr;

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef MEM_MISALIGN_CHECK_EN
  assign req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  assign req_bad = req_illegal || req_misalign;

  // Controller mode encoding differs from funct3 size field
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_mode = 2'b01;
      2'b01:   req_mode = 2'b10;
      default: req_mode = 2'b00;
    endcase
  end

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  load_ext = {24'b0, d[7:0]};
      3'b101:  load_ext = {16'b0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d = req_funct3;
          if (req_bad) begin
            // rejected without touching the controller-facing registers
            rdata_d = 32'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = req_addr[ADDR_W-1:0];
            we_d    = req_we;
            mode_d  = req_mode;
            wdata_d = req_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_op_r) begin
          rdata_d = we_q ? 32'b0 : load_ext(f3_q, mem_rdata);
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
            rdata_d = 32'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      mode_q  <= 2'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_enable = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_mode   = mode_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench: byte-array memory model predicts each response and its cycle.
module tb_mem_request_master;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_op_r = 1'b0;
  logic        mem_enable;
  logic [1:0]  mem_mode;

  mem_request_master #(.ADDR_W(24), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_op_r(mem_op_r), .mem_enable(mem_enable),
    .mem_mode(mem_mode)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } exp_t;
  exp_t        rq[$];
  int          eq[$];
  int          total = 0, bad = 0, cyc = 0, rst_gen = 0;
  logic        mute = 1'b0;
  logic [31:0] last_rdata = 32'b0;
  logic        last_err = 1'b0;
  logic [7:0]  dev_mem [256];
  logic [7:0]  ref_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // Per-cycle compare of rsp_valid/rsp data and mem_enable against the model's schedule
  always @(negedge clk) begin
    logic ev, ee;
    if (rst_n) begin
      ev = (rq.size() > 0) && (rq[0].cyc == cyc);
      ee = (eq.size() > 0) && (eq[0] == cyc);
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
      chk("mem_enable", {31'b0, mem_enable}, {31'b0, ee});
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, rq[0].rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, rq[0].err});
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
      while (rq.size() > 0 && rq[0].cyc <= cyc) void'(rq.pop_front());
      while (eq.size() > 0 && eq[0] <= cyc) void'(eq.pop_front());
    end
  end

  // Controller stub: op_r five cycles after enable, zero-filled read data
  initial begin
    logic [23:0] sa; logic swe; logic [1:0] sm; logic [31:0] swd; int g; logic [7:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && mem_enable && !mute) begin
        sa = mem_addr; swe = mem_we; sm = mem_mode; swd = mem_wdata; g = rst_gen;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (g == rst_gen) begin
            chk("hold_addr", {8'b0, mem_addr}, {8'b0, sa});
            chk("hold_we_mode", {29'b0, mem_we, mem_mode}, {29'b0, swe, sm});
            chk("hold_wdata", mem_wdata, swd);
          end
        end
        a = sa[7:0];
        case (sm)
          2'b01:   mem_rdata = {24'b0, dev_mem[a]};
          2'b10:   mem_rdata = {16'b0, dev_mem[8'(a+1)], dev_mem[a]};
          default: mem_rdata = {dev_mem[8'(a+3)], dev_mem[8'(a+2)], dev_mem[8'(a+1)], dev_mem[a]};
        endcase
        if (swe && g == rst_gen) begin
          dev_mem[a] = swd[7:0];
          if (sm != 2'b01) dev_mem[8'(a+1)] = swd[15:8];
          if (sm == 2'b00) begin dev_mem[8'(a+2)] = swd[23:16]; dev_mem[8'(a+3)] = swd[31:24]; end
        end
        mem_op_r = 1'b1;
        @(negedge clk);
        mem_op_r = 1'b0;
      end
    end
  end

  // Model: what the response must be and when, from the request alone
  task automatic predict(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] wd);
    exp_t e; logic rej; logic [7:0] a, b0, b1, b2, b3; int n;
    rej = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
`ifdef MEM_MISALIGN_CHECK_EN
    if ((f3[1:0] == 2'd1 && ad[0]) || (f3[1:0] == 2'd2 && ad[1:0] != 2'd0)) rej = 1'b1;
`endif
    e.rdata = 32'b0; e.err = 1'b1;
    if (rej) e.cyc = k + 1;
    else if (mute) begin e.cyc = k + 2 + TO; eq.push_back(k + 1); end
    else begin
      eq.push_back(k + 1);
      e.cyc = k + 7; e.err = 1'b0;
      a = ad[7:0];
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
      end else begin
        b0 = ref_mem[a]; b1 = ref_mem[8'(a+1)]; b2 = ref_mem[8'(a+2)]; b3 = ref_mem[8'(a+3)];
        case (f3)
          3'd0: e.rdata = {{24{b0[7]}}, b0};
          3'd1: e.rdata = {{16{b1[7]}}, b1, b0};
          3'd4: e.rdata = {24'b0, b0};
          3'd5: e.rdata = {16'b0, b1, b0};
          default: e.rdata = {b3, b2, b1, b0};
        endcase
      end
    end
    rq.push_back(e);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [31:0] wd);
    int i;
    @(negedge clk);
    for (i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = ad; req_wdata = wd;
    predict(cyc, we, f3, ad, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60 && rq.size() > 0; i++) @(negedge clk);
    if (rq.size() > 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      rq.delete(); eq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin dev_mem[i] = 8'(i * 7 + 3); ref_mem[i] = 8'(i * 7 + 3); end
    dev_mem[8'h10] = 8'haa; dev_mem[8'h11] = 8'hbb; dev_mem[8'h12] = 8'hcc; dev_mem[8'h13] = 8'hdd;
    dev_mem[8'h04] = 8'h80; dev_mem[8'h20] = 8'h34; dev_mem[8'h21] = 8'hf2;
    dev_mem[8'h02] = 8'h11; dev_mem[8'h03] = 8'h22;
    for (int i = 0; i < 256; i++) ref_mem[i] = dev_mem[i];

    #3;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_outs", {28'b0, rsp_valid, rsp_err, mem_enable, mem_we}, 32'd0);
    chk("reset_bus", {8'b0, mem_addr} | rsp_rdata | mem_wdata | {30'b0, mem_mode}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 3'b010, 32'h10, 32'h0); wait_done();
    chk("lw_0x10", last_rdata, 32'hddccbbaa);
    do_req(1'b0, 3'b000, 32'h04, 32'h0); wait_done();
    chk("lb_0x04", last_rdata, 32'hffffff80);
    do_req(1'b0, 3'b100, 32'h04, 32'h0); wait_done();
    chk("lbu_0x04", last_rdata, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h20, 32'h0); wait_done();
    chk("lh_0x20", last_rdata, 32'hfffff234);

    do_req(1'b1, 3'b001, 32'h08, 32'h1234abcd);
    chk("sh_mode_we", {29'b0, mem_enable, mem_we, mem_mode[1]}, 32'd7);
    wait_done();
    chk("sh_rdata", last_rdata, 32'h0);
    do_req(1'b0, 3'b101, 32'h08, 32'h0); wait_done();
    chk("lhu_0x08", last_rdata, 32'h0000abcd);

    mute = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'h0); wait_done();
    chk("timeout_err", {31'b0, last_err}, 32'd1);
    mute = 1'b0;
    mem_op_r = 1'b1; @(negedge clk); mem_op_r = 1'b0;
    repeat (4) @(negedge clk);

    do_req(1'b0, 3'b011, 32'h10, 32'h0); wait_done();
    chk("f3_011_err", {31'b0, last_err}, 32'd1);
    do_req(1'b1, 3'b100, 32'h10, 32'h55); wait_done();
    chk("store_f3_100_err", {31'b0, last_err}, 32'd1);
    do_req(1'b0, 3'b010, 32'h02, 32'h0); wait_done();
`ifdef MEM_MISALIGN_CHECK_EN
    chk("lw_0x02_err", {31'b0, last_err}, 32'd1);
`else
    chk("lw_0x02", last_rdata, {ref_mem[5], ref_mem[4], 16'h2211});
`endif

    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    rq.delete(); eq.delete(); rst_gen++;
    #1;
    chk("mid_reset_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_reset_outs", {28'b0, rsp_valid, rsp_err, mem_enable, mem_we}, 32'd0);
    chk("mid_reset_bus", {8'b0, mem_addr} | rsp_rdata | mem_wdata | {30'b0, mem_mode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_req(1'b0, 3'b010, 32'h10, 32'h0); wait_done();
    chk("lw_after_reset", last_rdata, 32'hddccbbaa);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end
endmodule
